// File: rtl/ipsl_pcie_dma_defines_pkg.sv
// Shared definitions for the PCIe DMA datapath: skid-buffer state encodings
// and default TLP beat widths.
package ipsl_pcie_dma_defines_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_USER_WIDTH = 8;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/ipsl_pcie_sat_cnt.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// and is cleared only by the asynchronous reset.
module ipsl_pcie_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ipsl_pcie_dma_skid_buf.sv
// Valid/ready register slice with a 2-entry skid buffer for DMA TLP beats.
// Optional stall counter output enabled by IPSL_PCIE_SKID_STALL_CNT_EN.
module ipsl_pcie_dma_skid_buf
  import ipsl_pcie_dma_defines_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [USER_WIDTH-1:0] in_user,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  out_last,
  input  logic                  out_ready
`ifdef IPSL_PCIE_SKID_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  logic [1:0]            state_q,     state_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [USER_WIDTH-1:0] main_user_q, main_user_d;
  logic                  main_last_q, main_last_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [USER_WIDTH-1:0] skid_user_q, skid_user_d;
  logic                  skid_last_q, skid_last_d;
  logic                  accept;

  // A beat only counts when the registered ready was high this cycle.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    main_data_d = main_data_q;
    main_user_d = main_user_q;
    main_last_d = main_last_q;
    skid_data_d = skid_data_q;
    skid_user_d = skid_user_q;
    skid_last_d = skid_last_q;

    case (state_q)
      ST_EMPTY: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (accept) begin
          main_data_d = in_data;
          main_user_d = in_user;
          main_last_d = in_last;
          out_valid_d = 1'b1;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          main_data_d = in_data;
          main_user_d = in_user;
          main_last_d = in_last;
        end else if (accept) begin
          skid_data_d = in_data;
          skid_user_d = in_user;
          skid_last_d = in_last;
          in_ready_d  = 1'b0;
          state_d     = ST_FULL;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          main_data_d = skid_data_q;
          main_user_d = skid_user_q;
          main_last_d = skid_last_q;
          in_ready_d  = 1'b1;
          state_d     = ST_ONE;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_user_q <= '0;
      main_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_user_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_data_q <= main_data_d;
      main_user_q <= main_user_d;
      main_last_q <= main_last_d;
      skid_data_q <= skid_data_d;
      skid_user_q <= skid_user_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_user  = main_user_q;
  assign out_last  = main_last_q;

`ifdef IPSL_PCIE_SKID_STALL_CNT_EN
  ipsl_pcie_sat_cnt #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid_q && !out_ready),
    .cnt   (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ipsl_pcie_dma_skid_buf.sv
// Self-checking bench for ipsl_pcie_dma_skid_buf: a FIFO-occupancy model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_ipsl_pcie_dma_skid_buf;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   u;
    logic         l;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic [7:0]   in_user;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic [7:0]   out_user;
  logic         out_last;
  logic         out_ready;
`ifdef IPSL_PCIE_SKID_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int compareCount = 0;
  int failCount    = 0;

  beat_t modelQ[$];
  logic  modelReady;
  int    modelStall;

  ipsl_pcie_dma_skid_buf #(
    .DATA_WIDTH (128),
    .USER_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_user   (in_user),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_user  (out_user),
    .out_last  (out_last),
    .out_ready (out_ready)
`ifdef IPSL_PCIE_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The buffer behaves as a 2-deep FIFO whose ready reflects occupancy after the edge.
  task automatic modelReset();
    modelQ.delete();
    modelReady = 1'b0;
    modelStall = 0;
  endtask

  task automatic modelUpdate();
    logic  acc;
    logic  pop;
    beat_t b;
    if (!rst_n) begin
      modelReset();
    end else begin
      acc = in_valid && modelReady;
      pop = (modelQ.size() > 0) && out_ready;
      if ((modelQ.size() > 0) && !out_ready && (modelStall < 65535)) modelStall++;
      if (pop) void'(modelQ.pop_front());
      if (acc) begin
        b.d = in_data;
        b.u = in_user;
        b.l = in_last;
        modelQ.push_back(b);
      end
      modelReady = (modelQ.size() < 2);
    end
  endtask

  task automatic checkOutput();
    checkVal("model_in_ready", in_ready, modelReady);
    checkVal("model_out_valid", out_valid, modelQ.size() > 0);
    if (modelQ.size() > 0) begin
      checkVal("model_out_data", out_data, modelQ[0].d);
      checkVal("model_out_user", out_user, modelQ[0].u);
      checkVal("model_out_last", out_last, modelQ[0].l);
    end
`ifdef IPSL_PCIE_SKID_STALL_CNT_EN
    checkVal("model_stall_cnt", stall_cnt, modelStall);
`endif
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] d, input logic [7:0] u,
                               input logic l, input logic r);
    in_valid  = v;
    in_data   = d;
    in_user   = u;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0;
    modelReset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

    // Reset and release
    @(negedge clk);
    checkOutput();
    @(negedge clk);
    checkVal("reset_in_ready", in_ready, 0);
    checkVal("reset_out_valid", out_valid, 0);
    checkVal("reset_out_data", out_data, 0);
    rst_n = 1'b1;
    stepCycle();
    checkVal("release_in_ready", in_ready, 1);
    checkVal("release_out_valid", out_valid, 0);

    // Eight-beat stream at full rate
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 128'(i), 8'(i + 16), i == 7, 1'b1);
      stepCycle();
      checkVal("stream_valid", out_valid, 1);
      checkVal("stream_data", out_data, 128'(i));
    end
    checkVal("stream_last", out_last, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    stepCycle();
    checkVal("stream_drained", out_valid, 0);

    // Skid capture and release
    applyStimulus(1'b1, 128'hA, 8'h1A, 1'b0, 1'b0);
    stepCycle();
    checkVal("skid_a_out", out_data, 128'hA);
    applyStimulus(1'b1, 128'hB, 8'h1B, 1'b1, 1'b0);
    stepCycle();
    checkVal("skid_full_ready", in_ready, 0);
    checkVal("skid_hold_a", out_data, 128'hA);
    applyStimulus(1'b1, 128'hC, 8'h1C, 1'b0, 1'b0);
    stepCycle();
    checkVal("skid_ignore_c", out_data, 128'hA);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    stepCycle();
    checkVal("skid_b_out", out_data, 128'hB);
    checkVal("skid_b_last", out_last, 1);
    checkVal("skid_ready_back", in_ready, 1);
    stepCycle();
    checkVal("skid_drained", out_valid, 0);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom},
                    8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      stepCycle();
    end

    // Reset asserted while full
    applyStimulus(1'b1, 128'h11, 8'h01, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 128'h22, 8'h02, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkVal("full_before_reset", in_ready, 0);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkVal("midreset_out_valid", out_valid, 0);
    checkVal("midreset_in_ready", in_ready, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkVal("post_reset_quiet", out_valid, 0);
    end

`ifdef IPSL_PCIE_SKID_STALL_CNT_EN
    // Long stall drives the counter into saturation
    applyStimulus(1'b1, 128'h5A, 8'h5A, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      stepCycle();
    end
    checkVal("stall_saturated", stall_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
